// File: rtl/alu_seq_if.sv
// alu_seq operand/result handshake bundle.
// master drives operands and out_ready; slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [3:0]       opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, num1, num2, opcode, out_ready,
    input  in_ready, out_valid, result,
    input  flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, num1, num2, opcode, out_ready,
    output in_ready, out_valid, result,
    output flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and flags.
// Define ALU_MUL_EN to build the iterative shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SHL = 4'b0110;
  localparam logic [3:0] OP_SHR = 4'b0111;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1000;
  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, DONE
  } state_t;
`endif

  state_t state, state_d;

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] r;
  logic             c, v;

  logic [WIDTH-1:0] res_q;
  logic             z_q, n_q, c_q, v_q;

  assign a      = bus.num1;
  assign b      = bus.num2;
  assign sh     = b[SHW-1:0];
  assign sum    = {1'b0, a} + {1'b0, b};
  assign diff   = {1'b0, a} - {1'b0, b};
  assign accept = (state == IDLE) && bus.in_valid;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand, acc, acc_d;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic               last;

  assign is_mul = (bus.opcode == OP_MUL);
  assign acc_d  = mplier[0] ? acc + mcand : acc;
  assign last   = (cnt == SHW'(WIDTH - 1));
`else
  assign is_mul = 1'b0;
`endif

  // single-cycle ops evaluate straight from the bus on the accept edge
  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (1'b1)
      bus.opcode == OP_ADD: begin
        r = sum[WIDTH-1:0];
        c = sum[WIDTH];
        v = (a[WIDTH-1] == b[WIDTH-1]) &&
            (r[WIDTH-1] != a[WIDTH-1]);
      end
      bus.opcode == OP_SUB: begin
        r = diff[WIDTH-1:0];
        c = diff[WIDTH];
        v = (a[WIDTH-1] != b[WIDTH-1]) &&
            (r[WIDTH-1] != a[WIDTH-1]);
      end
      bus.opcode == OP_AND: r = a & b;
      bus.opcode == OP_OR:  r = a | b;
      bus.opcode == OP_XOR: r = a ^ b;
      bus.opcode == OP_SHL: r = a << sh;
      bus.opcode == OP_SHR: r = a >> sh;
      default: r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (accept) state_d = is_mul ? state_t'(DONE + 0) : DONE;
`ifdef ALU_MUL_EN
        if (accept && is_mul) state_d = BUSY;
`endif
      end
`ifdef ALU_MUL_EN
      BUSY: if (last) state_d = DONE;
`endif
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (accept && !is_mul) begin
      res_q <= r;
      z_q   <= (r == '0);
      n_q   <= r[WIDTH-1];
      c_q   <= c;
      v_q   <= v;
    end
`ifdef ALU_MUL_EN
    else if (state == BUSY && last) begin
      res_q <= acc_d[WIDTH-1:0];
      z_q   <= (acc_d[WIDTH-1:0] == '0);
      n_q   <= acc_d[WIDTH-1];
      c_q   <= |acc_d[2*WIDTH-1:WIDTH];
      v_q   <= 1'b0;
    end
`endif
  end

`ifdef ALU_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (accept && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_d;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
    end
  end
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=16).
// MUL scenarios follow the ALU_MUL_EN build option.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  f;
  } exp_t;

  exp_t sb[$];

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic [15:0] r,
                      input logic z, input logic n,
                      input logic c, input logic v);
    exp_t e;
    e.r = r;
    e.f = {z, n, c, v};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready got %b want 1", bus.in_ready);
    end
    bus.opcode   = op;
    bus.num1     = a;
    bus.num2     = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input string name, input int lat_exp);
    int   lat;
    exp_t e;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != lat_exp) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, lat_exp);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_scoreboard got empty want entry", name);
    end else begin
      e = sb.pop_front();
      if (bus.result !== e.r) begin
        errors++;
        $display("FAIL %s_result got %h want %h", name, bus.result, e.r);
      end
      checks++;
      if ({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== e.f) begin
        errors++;
        $display("FAIL %s_flags zncv got %b want %b", name,
                 {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, e.f);
      end
    end
    if (bus.out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.num1      = '0;
    bus.num2      = '0;
    bus.opcode    = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.result} !== 17'd0) begin
      errors++;
      $display("FAIL reset_out got %b/%h want 0/0", bus.out_valid, bus.result);
    end
    checks++;
    if ({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000",
               {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    push(16'h8000, 0, 1, 0, 1);
    issue(4'b0001, 16'h7FFF, 16'h0001);
    collect("add_ovf", 0);
    push(16'h0000, 1, 0, 1, 0);
    issue(4'b0001, 16'hFFFF, 16'h0001);
    collect("add_carry", 0);
  endtask

  task automatic test_sub();
    push(16'hFFFE, 0, 1, 1, 0);
    issue(4'b0010, 16'h0003, 16'h0005);
    collect("sub_borrow", 0);
    push(16'h7FFF, 0, 0, 0, 1);
    issue(4'b0010, 16'h8000, 16'h0001);
    collect("sub_ovf", 0);
  endtask

  task automatic test_logic();
    push(16'hF000, 0, 1, 0, 0);
    issue(4'b0011, 16'hF0F0, 16'hFF00);
    collect("and", 0);
    push(16'h0FF0, 0, 0, 0, 0);
    issue(4'b0100, 16'h0F00, 16'h00F0);
    collect("or", 0);
    push(16'h0000, 1, 0, 0, 0);
    issue(4'b0101, 16'hAAAA, 16'hAAAA);
    collect("xor", 0);
  endtask

  task automatic test_shift();
    push(16'h0008, 0, 0, 0, 0);
    issue(4'b0110, 16'h0001, 16'h0013);
    collect("shl", 0);
    push(16'h0001, 0, 0, 0, 0);
    issue(4'b0111, 16'h8000, 16'h000F);
    collect("shr", 0);
    push(16'h1234, 0, 0, 0, 0);
    issue(4'b0110, 16'h1234, 16'h0010);
    collect("shl_zero", 0);
  endtask

  task automatic test_undef();
    push(16'h0000, 1, 0, 0, 0);
    issue(4'b1111, 16'h1234, 16'h5678);
    collect("op_f", 0);
    push(16'h0000, 1, 0, 0, 0);
    issue(4'b0000, 16'hFFFF, 16'hFFFF);
    collect("op_0", 0);
  endtask

  task automatic test_mul();
`ifdef ALU_MUL_EN
    int   low;
    int   lat;
    exp_t e;
    push(16'h0000, 1, 0, 1, 0);
    issue(4'b1000, 16'h0100, 16'h0100);
    low = 1;
    lat = -1;
    while (!bus.in_ready && low < 64) begin
      if (bus.out_valid && lat < 0) begin
        lat = low - 1;
        e = sb.pop_front();
        checks++;
        if ({bus.result, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}
            !== {e.r, e.f}) begin
          errors++;
          $display("FAIL mul_big got %h/%b want %h/%b", bus.result,
                   {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}, e.r, e.f);
        end
      end
      @(posedge clk); #1;
      low++;
    end
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL mul_latency got %0d want 16", lat);
    end
    checks++;
    if (low != 18) begin
      errors++;
      $display("FAIL mul_busy_cycles got %0d want 17", low - 1);
    end
    push(16'h02FD, 0, 0, 0, 0);
    issue(4'b1000, 16'h00FF, 16'h0003);
    collect("mul_small", 16);
`else
    push(16'h0000, 1, 0, 0, 0);
    issue(4'b1000, 16'h0100, 16'h0100);
    collect("mul_off", 0);
`endif
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    push(16'h0002, 0, 0, 0, 0);
    issue(4'b0001, 16'h0001, 16'h0001);
    collect("bp", 0);
    for (int i = 0; i < 5; i++) begin
      bus.opcode   = 4'b0010;
      bus.num1     = 16'h0009;
      bus.num2     = 16'h0004;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b10, 16'h0002}) begin
        errors++;
        $display("FAIL bp_hold%0d got v%b r%b %h want v1 r0 0002",
                 i, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.result} !== {2'b01, 16'h0002}) begin
      errors++;
      $display("FAIL bp_release got v%b r%b %h want v0 r1 0002",
               bus.out_valid, bus.in_ready, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, b, r;
    logic [16:0] s;
    logic        v;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 2 == 0) begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0];
        v = (a[15] == b[15]) && (r[15] != a[15]);
        push(r, r == 16'h0, r[15], s[16], v);
        issue(4'b0001, a, b);
      end else begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0];
        v = (a[15] != b[15]) && (r[15] != a[15]);
        push(r, r == 16'h0, r[15], a < b, v);
        issue(4'b0010, a, b);
      end
      collect("b2b", 0);
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b want 1", i, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset_mid();
`ifdef ALU_MUL_EN
    issue(4'b1000, 16'h0100, 16'h0100);
    repeat (4) @(posedge clk);
    #1;
`else
    bus.out_ready = 1'b0;
    issue(4'b0001, 16'h4321, 16'h1111);
    @(posedge clk); #1;
`endif
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if ({bus.out_valid, bus.result} !== 17'd0) begin
      errors++;
      $display("FAIL midrst_out got %b/%h want 0/0", bus.out_valid, bus.result);
    end
    checks++;
    if ({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_flags got %b want 0000",
               {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_ready got %b want 1", bus.in_ready);
    end
    push(16'h0005, 0, 0, 0, 0);
    issue(4'b0001, 16'h0002, 16'h0003);
    collect("post_rst_add", 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_shift();
    test_undef();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
